rv32_control_unit: RTL and testbench
====================================

// Module: rv32_control_unit
// PURPOSE
//   Main decoder of the RV32I core: maps opcode/funct3/funct7 to datapath controls
//   (register write, memory access, branch/jump, ALU operand select, writeback select, ALU op).
//   Decode is combinational; every output is registered, giving one cycle of latency.
//   It sits between the instruction fetch/decode stage and the execute/memory/writeback datapath.
// PARAMETERS
//   None. The encodings below are fixed localparams.
//   ALU_CTRL: ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLL=5 SRL=6 SRA=7 SLT=8 SLTU=9
//             BEQ=A BNE=B BLT=C BGE=D BLTU=E BGEU=F.
// PORTS
//   clk          in   1  single clock; all outputs update on the rising edge
//   rst          in   1  synchronous, active-high reset
//   opcode       in   7  instr[6:0]
//   funct3       in   3  instr[14:12]
//   funct7       in   7  instr[31:25]; only bit 5 is examined
//   reg_write    out  1  write rd
//   mem_read     out  1  data memory load
//   mem_write    out  1  data memory store
//   branch       out  1  conditional branch; the ALU evaluates the condition
//   jump         out  1  unconditional jump (JAL/JALR)
//   alu_src      out  1  0=rs2, 1=immediate as ALU operand B
//   mem_to_reg   out  2  writeback select: 00=ALU, 01=memory, 10=PC+4
//   alu_ctrl     out  4  ALU operation (encoding above)
//   lui_instr    out  1  LUI marker
//   auipc_instr  out  1  AUIPC marker
//   illegal_instr out 1  opcode not recognised, or branch funct3 is 010/011
// BEHAVIOUR
//   Reset and timing
//   - Reset gives the NOP state: all 1-bit outputs 0, mem_to_reg=00, alu_ctrl=ADD.
//     rst has priority over any decode in the same cycle.
//   - Outputs reflect the inputs sampled at the previous rising edge.
//     Back-to-back instructions are decoded every cycle; there is no handshake.
//   Per-opcode decode. Fields not listed take NOP values.
//   - LUI 0110111: reg_write=1, alu_src=1, alu=ADD, lui_instr=1.
//   - AUIPC 0010111: reg_write=1, alu_src=1, alu=ADD, auipc_instr=1.
//   - JAL 1101111 and JALR 1100111: reg_write=1, jump=1, alu_src=1, mem_to_reg=10,
//     alu=ADD. funct3 is ignored.
//   - BRANCH 1100011: branch=1, alu_src=0.
//     funct3 000/001/100/101/110/111 -> BEQ/BNE/BLT/BGE/BLTU/BGEU.
//     funct3 010/011 -> alu=BEQ, branch=1 still, illegal_instr=1.
//   - LOAD 0000011: reg_write=1, mem_read=1, alu_src=1, mem_to_reg=01, alu=ADD.
//     funct3 is ignored; access width is handled downstream.
//   - STORE 0100011: mem_write=1, alu_src=1, alu=ADD. funct3 is ignored.
//   - OP-IMM 0010011: reg_write=1, alu_src=1.
//     funct3 000/010/011/100/110/111/001 -> ADD/SLT/SLTU/XOR/OR/AND/SLL.
//     funct3 101 -> SRA if funct7[5] else SRL.
//     funct7 is ignored for every other funct3 (no SUBI).
//   - OP 0110011: reg_write=1, alu_src=0. Same funct3 map as OP-IMM.
//     funct3 000 -> SUB if funct7[5] else ADD.
//     funct3 101 -> SRA if funct7[5] else SRL.
//   - Any other opcode (e.g. 1111111): NOP values, illegal_instr=1.
//   Invariants
//   - mem_read and mem_write are never both 1.
//   - lui_instr and auipc_instr are mutually exclusive.
//   - X-free outputs are guaranteed for known inputs.
// TESTING
//   - Reset: rst=1 for 2 edges -> all flags 0, mem_to_reg=00, alu_ctrl=0000.
//     Then release rst.
//   - LUI and AUIPC: 1 edge after apply -> reg_write=1, alu_src=1, alu_ctrl=0000,
//     lui_instr=1 (LUI) or auipc_instr=1 (AUIPC).
//   - JAL/JALR -> jump=1, mem_to_reg=10.
//     LOAD -> mem_read=1, mem_to_reg=01.
//     STORE -> mem_write=1, reg_write=0.
//   - BRANCH, all funct3: 000->1010, 001->1011, 100->1100, 101->1101, 110->1110,
//     111->1111, 010->1010 with illegal_instr=1.
//   - OP funct3=000: funct7=0000000 -> 0000, 0100000 -> 0001.
//     funct3=101: funct7=0000000 -> 0110, 0100000 -> 0111.
//     OP-IMM funct3=011 with funct7=1111111 -> 1001, alu_src=1.
//   - Opcode 1111111, funct3=111, funct7=1111111 -> NOP values, illegal_instr=1.
//     Assert rst in the same cycle as a valid opcode -> NOP on the next edge.

Source files
------------

// File: rtl/rv32_control_unit.sv
// RV32I main decoder: opcode/funct3/funct7 -> datapath controls, all registered (1-cycle latency).
module rv32_control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       branch,
  output logic       jump,
  output logic       alu_src,
  output logic [1:0] mem_to_reg,
  output logic [3:0] alu_ctrl,
  output logic       lui_instr,
  output logic       auipc_instr,
  output logic       illegal_instr
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_SLL  = 4'h5;
  localparam logic [3:0] ALU_SRL  = 4'h6;
  localparam logic [3:0] ALU_SRA  = 4'h7;
  localparam logic [3:0] ALU_SLT  = 4'h8;
  localparam logic [3:0] ALU_SLTU = 4'h9;
  localparam logic [3:0] ALU_BEQ  = 4'hA;
  localparam logic [3:0] ALU_BNE  = 4'hB;
  localparam logic [3:0] ALU_BLT  = 4'hC;
  localparam logic [3:0] ALU_BGE  = 4'hD;
  localparam logic [3:0] ALU_BLTU = 4'hE;
  localparam logic [3:0] ALU_BGEU = 4'hF;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // Only funct7[5] carries meaning in RV32I base decode.
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  logic       reg_write_next, mem_read_next, mem_write_next, branch_next, jump_next;
  logic       alu_src_next, lui_instr_next, auipc_instr_next, illegal_instr_next;
  logic [1:0] mem_to_reg_next;
  logic [3:0] alu_ctrl_next;

  // Shared OP/OP-IMM funct3 map; allow_sub is false for OP-IMM since SUBI does not exist.
  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic f7_5,
                                          input logic allow_sub);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (allow_sub && f7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  always_comb begin
    reg_write_next     = 1'b0;
    mem_read_next      = 1'b0;
    mem_write_next     = 1'b0;
    branch_next        = 1'b0;
    jump_next          = 1'b0;
    alu_src_next       = 1'b0;
    mem_to_reg_next    = WB_ALU;
    alu_ctrl_next      = ALU_ADD;
    lui_instr_next     = 1'b0;
    auipc_instr_next   = 1'b0;
    illegal_instr_next = 1'b0;
    case (opcode)
      OP_LUI: begin
        reg_write_next = 1'b1;
        alu_src_next   = 1'b1;
        lui_instr_next = 1'b1;
      end
      OP_AUIPC: begin
        reg_write_next   = 1'b1;
        alu_src_next     = 1'b1;
        auipc_instr_next = 1'b1;
      end
      OP_JAL, OP_JALR: begin
        reg_write_next  = 1'b1;
        jump_next       = 1'b1;
        alu_src_next    = 1'b1;
        mem_to_reg_next = WB_PC4;
      end
      OP_BRANCH: begin
        branch_next = 1'b1;
        case (funct3)
          3'b000:  alu_ctrl_next = ALU_BEQ;
          3'b001:  alu_ctrl_next = ALU_BNE;
          3'b100:  alu_ctrl_next = ALU_BLT;
          3'b101:  alu_ctrl_next = ALU_BGE;
          3'b110:  alu_ctrl_next = ALU_BLTU;
          3'b111:  alu_ctrl_next = ALU_BGEU;
          default: begin
            alu_ctrl_next      = ALU_BEQ;
            illegal_instr_next = 1'b1;
          end
        endcase
      end
      OP_LOAD: begin
        reg_write_next  = 1'b1;
        mem_read_next   = 1'b1;
        alu_src_next    = 1'b1;
        mem_to_reg_next = WB_MEM;
      end
      OP_STORE: begin
        mem_write_next = 1'b1;
        alu_src_next   = 1'b1;
      end
      OP_IMM: begin
        reg_write_next = 1'b1;
        alu_src_next   = 1'b1;
        alu_ctrl_next  = arith_op(funct3, funct7[5], 1'b0);
      end
      OP_REG: begin
        reg_write_next = 1'b1;
        alu_ctrl_next  = arith_op(funct3, funct7[5], 1'b1);
      end
      default: illegal_instr_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write     <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      branch        <= 1'b0;
      jump          <= 1'b0;
      alu_src       <= 1'b0;
      mem_to_reg    <= WB_ALU;
      alu_ctrl      <= ALU_ADD;
      lui_instr     <= 1'b0;
      auipc_instr   <= 1'b0;
      illegal_instr <= 1'b0;
    end else begin
      reg_write     <= reg_write_next;
      mem_read      <= mem_read_next;
      mem_write     <= mem_write_next;
      branch        <= branch_next;
      jump          <= jump_next;
      alu_src       <= alu_src_next;
      mem_to_reg    <= mem_to_reg_next;
      alu_ctrl      <= alu_ctrl_next;
      lui_instr     <= lui_instr_next;
      auipc_instr   <= auipc_instr_next;
      illegal_instr <= illegal_instr_next;
    end
  end

endmodule

// File: tb/tb_rv32_control_unit.sv
// Directed-vector bench for rv32_control_unit; expected control words are hand-computed.
module tb_rv32_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       reg_write, mem_read, mem_write, branch, jump, alu_src;
  logic [1:0] mem_to_reg;
  logic [3:0] alu_ctrl;
  logic       lui_instr, auipc_instr, illegal_instr;

  int checks_reg = 0;
  int errors_reg = 0;

  rv32_control_unit dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .jump(jump), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
    .alu_ctrl(alu_ctrl), .lui_instr(lui_instr), .auipc_instr(auipc_instr),
    .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  // Control word layout: rw mr mw br j as m2r[1:0] alu[3:0] lui auipc ill
  function automatic logic [14:0] ctl(input logic rw, mr, mw, br, j, as,
                                      input logic [1:0] m2r, input logic [3:0] alu,
                                      input logic lui, auipc, ill);
    return {rw, mr, mw, br, j, as, m2r, alu, lui, auipc, ill};
  endfunction

  function automatic logic [14:0] observed();
    return {reg_write, mem_read, mem_write, branch, jump, alu_src, mem_to_reg,
            alu_ctrl, lui_instr, auipc_instr, illegal_instr};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_reg++;
    if (obs !== exp) begin
      errors_reg++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run(input string tag, input logic [6:0] op, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [14:0] exp);
    @(negedge clk);
    rst    = 1'b0;
    opcode = op;
    funct3 = f3;
    funct7 = f7;
    @(posedge clk);
    #1;
    $display("txn %-10s op=%b f3=%b f7=%b ctl=%b", tag, op, f3, f7, observed());
    check(tag, {17'd0, observed()}, {17'd0, exp});
    check({tag, "_inv"}, {30'd0, mem_read & mem_write, lui_instr & auipc_instr}, 32'd0);
  endtask

  initial begin
    rst    = 1'b1;
    opcode = 7'b0110111;
    funct3 = 3'b000;
    funct7 = 7'b0000000;
    repeat (2) @(posedge clk);
    #1;
    $display("txn reset      ctl=%b", observed());
    check("reset", {17'd0, observed()}, {17'd0, ctl(0,0,0,0,0,0,2'b00,4'h0,0,0,0)});

    run("lui",      7'b0110111, 3'b000, 7'h00, ctl(1,0,0,0,0,1,2'b00,4'h0,1,0,0));
    run("auipc",    7'b0010111, 3'b101, 7'h20, ctl(1,0,0,0,0,1,2'b00,4'h0,0,1,0));
    run("jal",      7'b1101111, 3'b000, 7'h00, ctl(1,0,0,0,1,1,2'b10,4'h0,0,0,0));
    run("jalr",     7'b1100111, 3'b011, 7'h00, ctl(1,0,0,0,1,1,2'b10,4'h0,0,0,0));
    run("load",     7'b0000011, 3'b010, 7'h00, ctl(1,1,0,0,0,1,2'b01,4'h0,0,0,0));
    run("store",    7'b0100011, 3'b001, 7'h00, ctl(0,0,1,0,0,1,2'b00,4'h0,0,0,0));
    run("beq",      7'b1100011, 3'b000, 7'h00, ctl(0,0,0,1,0,0,2'b00,4'hA,0,0,0));
    run("bne",      7'b1100011, 3'b001, 7'h00, ctl(0,0,0,1,0,0,2'b00,4'hB,0,0,0));
    run("blt",      7'b1100011, 3'b100, 7'h00, ctl(0,0,0,1,0,0,2'b00,4'hC,0,0,0));
    run("bge",      7'b1100011, 3'b101, 7'h00, ctl(0,0,0,1,0,0,2'b00,4'hD,0,0,0));
    run("bltu",     7'b1100011, 3'b110, 7'h00, ctl(0,0,0,1,0,0,2'b00,4'hE,0,0,0));
    run("bgeu",     7'b1100011, 3'b111, 7'h00, ctl(0,0,0,1,0,0,2'b00,4'hF,0,0,0));
    run("br_f3_010",7'b1100011, 3'b010, 7'h00, ctl(0,0,0,1,0,0,2'b00,4'hA,0,0,1));
    run("br_f3_011",7'b1100011, 3'b011, 7'h00, ctl(0,0,0,1,0,0,2'b00,4'hA,0,0,1));
    run("add",      7'b0110011, 3'b000, 7'h00, ctl(1,0,0,0,0,0,2'b00,4'h0,0,0,0));
    run("sub",      7'b0110011, 3'b000, 7'h20, ctl(1,0,0,0,0,0,2'b00,4'h1,0,0,0));
    run("srl",      7'b0110011, 3'b101, 7'h00, ctl(1,0,0,0,0,0,2'b00,4'h6,0,0,0));
    run("sra",      7'b0110011, 3'b101, 7'h20, ctl(1,0,0,0,0,0,2'b00,4'h7,0,0,0));
    run("sll",      7'b0110011, 3'b001, 7'h00, ctl(1,0,0,0,0,0,2'b00,4'h5,0,0,0));
    run("xor_f7",   7'b0110011, 3'b100, 7'h20, ctl(1,0,0,0,0,0,2'b00,4'h4,0,0,0));
    run("sltiu",    7'b0010011, 3'b011, 7'h7F, ctl(1,0,0,0,0,1,2'b00,4'h9,0,0,0));
    run("addi_f7",  7'b0010011, 3'b000, 7'h20, ctl(1,0,0,0,0,1,2'b00,4'h0,0,0,0));
    run("srai",     7'b0010011, 3'b101, 7'h20, ctl(1,0,0,0,0,1,2'b00,4'h7,0,0,0));
    run("srli",     7'b0010011, 3'b101, 7'h00, ctl(1,0,0,0,0,1,2'b00,4'h6,0,0,0));
    run("andi",     7'b0010011, 3'b111, 7'h00, ctl(1,0,0,0,0,1,2'b00,4'h2,0,0,0));
    run("ori",      7'b0010011, 3'b110, 7'h00, ctl(1,0,0,0,0,1,2'b00,4'h3,0,0,0));
    run("slti",     7'b0010011, 3'b010, 7'h00, ctl(1,0,0,0,0,1,2'b00,4'h8,0,0,0));
    run("illegal",  7'b1111111, 3'b111, 7'h7F, ctl(0,0,0,0,0,0,2'b00,4'h0,0,0,1));

    // Reset takes priority over a valid opcode presented in the same cycle.
    run("pre_rst",  7'b0000011, 3'b000, 7'h00, ctl(1,1,0,0,0,1,2'b01,4'h0,0,0,0));
    @(negedge clk);
    rst    = 1'b1;
    opcode = 7'b0110111;
    @(posedge clk);
    #1;
    $display("txn rst_vs_lui ctl=%b", observed());
    check("rst_vs_lui", {17'd0, observed()}, {17'd0, ctl(0,0,0,0,0,0,2'b00,4'h0,0,0,0)});

    // New inputs must not reach the outputs before the next rising edge.
    @(negedge clk);
    rst    = 1'b0;
    opcode = 7'b1101111;
    #1;
    check("latency_hold", {17'd0, observed()}, {17'd0, ctl(0,0,0,0,0,0,2'b00,4'h0,0,0,0)});
    @(posedge clk);
    #1;
    $display("txn latency    ctl=%b", observed());
    check("latency_jal", {17'd0, observed()}, {17'd0, ctl(1,0,0,0,1,1,2'b10,4'h0,0,0,0)});

    $display("CHECKS %0d ERRORS %0d", checks_reg, errors_reg);
    $finish;
  end

endmodule
